seq_detector: RTL and testbench
===============================

# seq_detector

Parametrised, overlap-aware symbol-sequence detector. It consumes one SYM_W-bit symbol per valid cycle and flags when the last PAT_LEN accepted symbols equal a compile-time PATTERN. It supports a sticky "pattern seen" mode and a pulse-per-match mode. It is the general successor to the team's fixed 2-bit three-symbol detectors, and sits directly on a symbol stream inside a larger datapath or test harness.

## Interface
- SYM_W, 2: symbol width in bits (≥1).
- PAT_LEN, 3: pattern length in symbols (2..16).
- PATTERN, 6'b11_10_01: packed pattern. Symbol i is PATTERN[i*SYM_W +: SYM_W]. Symbol 0 is received first.
- STICKY, 1: 1 = ans latches high after the first match; 0 = ans pulses once per match.
- CNT_W, 8: match-counter width (used only with SEQ_DET_COUNT_EN).
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear; same effect as reset, applied on the clock edge.
- in_valid  in  1  num is consumed this cycle.
- num  in  SYM_W  input symbol.
- ans  out  1  match indication (registered).
- match_cnt  out  CNT_W  saturating match count (present only with SEQ_DET_COUNT_EN).

## Operation
- State `prog`, width $clog2(PAT_LEN+1), holds the length of the longest pattern prefix that is also a suffix of the accepted input (KMP progress).
- Failure table `fail[k]` (k = 0..PAT_LEN) is computed at elaboration from PATTERN, with `fail[0] = fail[1] = 0`. No runtime logic is spent on it.
- On an edge with in_valid=1 and clear=0:
  - If `prog == PAT_LEN`, first set `k = fail[PAT_LEN]`; otherwise `k = prog`.
  - While `k > 0` and the symbol does not match pattern symbol k, set `k = fail[k]`. Unroll this as combinational logic.
  - If the symbol matches pattern symbol k, set `prog <= k+1`; else `prog <= 0`.
  - A match event occurs when the new `prog == PAT_LEN`.
- When in_valid=0, `prog`, ans and match_cnt hold; num is ignored (don't-care, may be X).
- STICKY=1:
  - Once a match event occurs, `done` is set and `ans=done` stays 1 until reset or clear.
  - Further input still advances `prog` but cannot lower ans.
- STICKY=0:
  - ans is a registered flag equal to "match event on the previous edge".
  - Overlapping matches each pulse; for example, pattern 1,2,1,2 on stream 1,2,1,2,1,2 matches twice.
  - Consecutive matches keep ans high on consecutive cycles.
- clear has priority over in_valid. On clear: `prog=0`, ans=0, match_cnt=0. A symbol presented in the clear cycle is discarded.
- Reset values: `prog=0`, `done=0`, ans=0, match_cnt=0.

## Timing
- Latency is 1 cycle. The edge that consumes the final pattern symbol raises ans immediately after that edge.
- Single-cycle throughput: one symbol per cycle, with no back-pressure.
- reset asserted mid-stream forces ans=0 asynchronously, without waiting for clk. Deassertion must be synchronous to clk (system-level guarantee). The first symbol is accepted on the first edge after deassertion.
- No combinational path from any input to any output.

## Configuration
- Macro: SEQ_DET_COUNT_EN.
- Defined:
  - Port match_cnt exists.
  - It increments by 1 on each match event, in both STICKY modes.
  - It saturates at 2^CNT_W−1 and never wraps.
  - It is zeroed by reset or clear.
- Undefined: match_cnt port and counter logic are absent. All other behaviour is identical.

## Structure
- Package `seq_det_pkg` contains:
  - a `prog_w(PAT_LEN)` function;
  - a `build_fail(PATTERN, SYM_W, PAT_LEN)` elaboration function;
  - the default-pattern constant `SEQ_DET_DEFAULT_PAT`.
- Sub-module `seq_det_sat_counter` (parameter W; inputs clk, reset, clear, inc; output cnt) holds the saturating counter. It is instantiated only under SEQ_DET_COUNT_EN.

## Test plan
- Default parameters; reset, then valid symbols 1,2,3 → ans=1 after the third edge and stays 1 through 20 further random symbols.
- Default parameters; stream 1,1,2,3 → ans rises after the fourth symbol (fallback keeps prefix length 1). Stream 1,2,2,3 → ans stays 0.
- Default parameters; 1, idle with num=X, 2, idle ×3, 3 → ans=1. Gaps with in_valid=0 do not disturb progress.
- PAT_LEN=4, PATTERN=1,2,1,2, STICKY=0; stream 1,2,1,2,1,2 → ans pulses for one cycle after symbols 4 and 6 only.
- Default parameters; stream 1,2, then clear, then 3 → ans=0. Separately, assert reset between clock edges after 1,2 → ans=0 at once, and 3 after deassertion gives no match.
- SEQ_DET_COUNT_EN, CNT_W=2, STICKY=0, PATTERN=1,2,3; five back-to-back patterns → match_cnt = 1,2,3,3,3, and clear returns it to 0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and elaboration-time helpers for seq_detector.
package seq_det_pkg;

    localparam int MAX_LEN = 16;
    localparam int FAIL_W = 5;
    localparam int MAX_PAT_BITS = 1024;
    localparam logic [5:0] SEQ_DET_DEFAULT_PAT = 6'b11_10_01;

    typedef logic [MAX_LEN:0][FAIL_W-1:0] fail_tab_t;

    function automatic int prog_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

    function automatic logic sym_eq(input logic [MAX_PAT_BITS-1:0] pat, input int sym_w,
                                    input int a, input int b);
        logic [MAX_PAT_BITS-1:0] mask;
        mask = (MAX_PAT_BITS'(1) << sym_w) - MAX_PAT_BITS'(1);
        return (((pat >> (a * sym_w)) ^ (pat >> (b * sym_w))) & mask) == '0;
    endfunction

    // Classic KMP failure function over prefix lengths; fail[0] = fail[1] = 0.
    function automatic fail_tab_t build_fail(input logic [MAX_PAT_BITS-1:0] pat, input int sym_w,
                                             input int pat_len);
        fail_tab_t f;
        int j;
        f = '0;
        for (int k = 2; k <= pat_len; k++) begin
            j = int'(f[k-1]);
            for (int n = 0; n < MAX_LEN; n++)
                if (j > 0 && !sym_eq(pat, sym_w, k - 1, j)) j = int'(f[j]);
            f[k] = FAIL_W'(sym_eq(pat, sym_w, k - 1, j) ? j + 1 : 0);
        end
        return f;
    endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// seq_det_sat_counter: saturating up-counter with async reset and sync clear.
module seq_det_sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else if (clear) cnt_q <= '0;
        else if (inc && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector.sv
// seq_detector: overlap-aware KMP symbol-sequence detector with sticky or pulse output.
// Define SEQ_DET_COUNT_EN to add the saturating match_cnt output.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int                       SYM_W   = 2,
    parameter int                       PAT_LEN = 3,
    parameter logic [PAT_LEN*SYM_W-1:0] PATTERN = SEQ_DET_DEFAULT_PAT,
    parameter bit                       STICKY  = 1'b1,
    parameter int                       CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] num,
`ifdef SEQ_DET_COUNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             ans
);

    localparam int PW = prog_w(PAT_LEN);
    localparam logic [PW-1:0] FULL = PW'(PAT_LEN);
    localparam fail_tab_t FAIL = build_fail(MAX_PAT_BITS'(PATTERN), SYM_W, PAT_LEN);

    logic [SYM_W-1:0] pat_sym [PAT_LEN+1];
    logic [PW-1:0]    fail_t  [PAT_LEN+1];
    logic [PW-1:0]    prog_q, prog_d, k;
    logic             ans_q, ans_d, hit;

    // Tables sized PAT_LEN+1 so a prog-width index always fits; the pad symbol is never compared.
    for (genvar i = 0; i <= PAT_LEN; i++) begin : g_tab
        assign fail_t[i] = PW'(FAIL[i]);
        if (i < PAT_LEN) begin : g_sym
            assign pat_sym[i] = PATTERN[i*SYM_W +: SYM_W];
        end else begin : g_pad
            assign pat_sym[i] = '0;
        end
    end

    always_comb begin
        k = (prog_q == FULL) ? fail_t[PAT_LEN] : prog_q;
        for (int i = 0; i < PAT_LEN; i++) k = (k != '0 && num != pat_sym[k]) ? fail_t[k] : k;
        prog_d = (num == pat_sym[k]) ? k + 1'b1 : '0;
        hit = prog_d == FULL;
        ans_d = STICKY ? (ans_q | hit) : hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prog_q <= '0;
            ans_q <= 1'b0;
        end else if (clear) begin
            prog_q <= '0;
            ans_q <= 1'b0;
        end else if (in_valid) begin
            prog_q <= prog_d;
            ans_q <= ans_d;
        end
    end

    assign ans = ans_q;

`ifdef SEQ_DET_COUNT_EN
    seq_det_sat_counter #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .inc  (in_valid & hit),
        .cnt  (match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: table-driven, scoreboarded checks of three seq_detector configurations.
module tb_seq_detector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] num = 2'd0;
    logic       ans_a, ans_b, ans_c;
`ifdef SEQ_DET_COUNT_EN
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
`endif

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic       clr;
        logic       vld;
        logic [1:0] sym;
        logic [2:0] exp;
    } vec_t;

    typedef struct {
        logic [2:0] mask;
        logic [2:0] val;
        int         id;
    } exp_t;

    vec_t tbl [31];
    exp_t sb [$];

    always #5 clk = ~clk;

    // a: default sticky 1,2,3; b: pulse 1,2,1,2; c: pulse 1,2,3 with a 2-bit counter
    seq_detector u_a (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .num(num),
`ifdef SEQ_DET_COUNT_EN
        .match_cnt(cnt_a),
`endif
        .ans(ans_a)
    );

    seq_detector #(.PAT_LEN(4), .PATTERN(8'b10_01_10_01), .STICKY(1'b0)) u_b (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .num(num),
`ifdef SEQ_DET_COUNT_EN
        .match_cnt(cnt_b),
`endif
        .ans(ans_b)
    );

    seq_detector #(.STICKY(1'b0), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .num(num),
`ifdef SEQ_DET_COUNT_EN
        .match_cnt(cnt_c),
`endif
        .ans(ans_c)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic c, input logic v, input logic [1:0] s,
                        input logic [2:0] mask, input logic [2:0] val, input int id);
        exp_t e;
        clear = c;
        in_valid = v;
        num = v ? s : 2'bxx;
        e.mask = mask;
        e.val = val;
        e.id = id;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.mask[2]) check($sformatf("ans_a[%0d]", e.id), {7'd0, ans_a}, {7'd0, e.val[2]});
        if (e.mask[1]) check($sformatf("ans_b[%0d]", e.id), {7'd0, ans_b}, {7'd0, e.val[1]});
        if (e.mask[0]) check($sformatf("ans_c[%0d]", e.id), {7'd0, ans_c}, {7'd0, e.val[0]});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl = '{
            '{1'b0, 1'b1, 2'd1, 3'b000}, '{1'b0, 1'b1, 2'd2, 3'b000}, '{1'b0, 1'b1, 2'd3, 3'b101},
            '{1'b0, 1'b1, 2'd1, 3'b100}, '{1'b1, 1'b1, 2'd2, 3'b000}, '{1'b0, 1'b1, 2'd1, 3'b000},
            '{1'b0, 1'b1, 2'd1, 3'b000}, '{1'b0, 1'b1, 2'd2, 3'b000}, '{1'b0, 1'b1, 2'd3, 3'b101},
            '{1'b1, 1'b0, 2'd0, 3'b000}, '{1'b0, 1'b1, 2'd1, 3'b000}, '{1'b0, 1'b1, 2'd2, 3'b000},
            '{1'b0, 1'b1, 2'd2, 3'b000}, '{1'b0, 1'b1, 2'd3, 3'b000}, '{1'b0, 1'b1, 2'd1, 3'b000},
            '{1'b0, 1'b0, 2'd0, 3'b000}, '{1'b0, 1'b1, 2'd2, 3'b000}, '{1'b0, 1'b0, 2'd0, 3'b000},
            '{1'b0, 1'b0, 2'd0, 3'b000}, '{1'b0, 1'b0, 2'd0, 3'b000}, '{1'b0, 1'b1, 2'd3, 3'b101},
            '{1'b0, 1'b0, 2'd0, 3'b101}, '{1'b1, 1'b0, 2'd0, 3'b000}, '{1'b0, 1'b1, 2'd1, 3'b000},
            '{1'b0, 1'b1, 2'd2, 3'b000}, '{1'b0, 1'b1, 2'd1, 3'b000}, '{1'b0, 1'b1, 2'd2, 3'b010},
            '{1'b0, 1'b1, 2'd1, 3'b000}, '{1'b0, 1'b1, 2'd2, 3'b010}, '{1'b0, 1'b1, 2'd3, 3'b101},
            '{1'b0, 1'b1, 2'd3, 3'b100}
        };
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ans_a", {7'd0, ans_a}, 8'd0);
        check("reset_ans_b", {7'd0, ans_b}, 8'd0);
        check("reset_ans_c", {7'd0, ans_c}, 8'd0);
`ifdef SEQ_DET_COUNT_EN
        check("reset_cnt_a", cnt_a, 8'd0);
        check("reset_cnt_c", {6'd0, cnt_c}, 8'd0);
`endif
        reset = 1'b0;
        for (int i = 0; i < 31; i++) step(tbl[i].clr, tbl[i].vld, tbl[i].sym, 3'b111, tbl[i].exp, i);
        // Sticky output must survive arbitrary traffic after a match.
        step(1'b1, 1'b0, 2'd0, 3'b111, 3'b000, 40);
        step(1'b0, 1'b1, 2'd1, 3'b100, 3'b000, 41);
        step(1'b0, 1'b1, 2'd2, 3'b100, 3'b000, 42);
        step(1'b0, 1'b1, 2'd3, 3'b101, 3'b101, 43);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 2'($urandom_range(0, 3)), 3'b100, 3'b100, 100 + i);
        // Asynchronous reset between edges after a partial 1,2 prefix.
        step(1'b0, 1'b1, 2'd1, 3'b100, 3'b100, 50);
        step(1'b0, 1'b1, 2'd2, 3'b100, 3'b100, 51);
        #2 reset = 1'b1;
        #1;
        check("async_reset_ans_a", {7'd0, ans_a}, 8'd0);
        check("async_reset_ans_b", {7'd0, ans_b}, 8'd0);
        check("async_reset_ans_c", {7'd0, ans_c}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b1, 2'd3, 3'b111, 3'b000, 52);
`ifdef SEQ_DET_COUNT_EN
        step(1'b1, 1'b0, 2'd0, 3'b111, 3'b000, 60);
        check("clear_cnt_c", {6'd0, cnt_c}, 8'd0);
        for (int n = 1; n <= 5; n++) begin
            step(1'b0, 1'b1, 2'd1, 3'b000, 3'b000, 60 + 3 * n);
            step(1'b0, 1'b1, 2'd2, 3'b000, 3'b000, 61 + 3 * n);
            step(1'b0, 1'b1, 2'd3, 3'b101, 3'b101, 62 + 3 * n);
            check($sformatf("cnt_c[%0d]", n), {6'd0, cnt_c}, 8'(n > 3 ? 3 : n));
            check($sformatf("cnt_a[%0d]", n), cnt_a, 8'(n));
        end
        check("cnt_b_no_match", cnt_b, 8'd0);
        step(1'b1, 1'b0, 2'd0, 3'b111, 3'b000, 80);
        check("clear_cnt_c_after", {6'd0, cnt_c}, 8'd0);
        check("clear_cnt_a_after", cnt_a, 8'd0);
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
